// File: rtl/serdes_pkg.sv
// Shared constants for the serial link: FSM encoding, default word width and frame length.
// Frame length grows by one parity bit when PISO_PARITY_EN is defined.
package serdes_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    function automatic int frame_len(input int width);
`ifdef PISO_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Load/shift-left register presenting its MSB; load takes priority over shift.
module piso_shift_reg
    import serdes_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_fast,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             msb
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            q <= {q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = q[WIDTH-1];

endmodule

// File: rtl/parallel_to_serial.sv
// Word-to-bit serializer, MSB first, with a one-entry hold buffer for gapless framing.
// Define PISO_PARITY_EN to append an even-parity bit after each word's LSB.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no frame on the wire; waits for the hold buffer to fill
// ST_SHIFT | frame bit on serial_out; reloads from hold at the last bit
module parallel_to_serial
    import serdes_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_fast,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] p_i,
    input  logic             p_valid,
    output logic             p_ready,
    output logic             serial_out,
    output logic             s_valid,
    output logic             s_last
);

    localparam int FLEN = frame_len(WIDTH);
    localparam int CW   = $clog2(FLEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(FLEN - 1);

    logic [0:0]       state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] hold_word;
    logic             hold_full;
    logic             last_bit;
    logic             load_en;
    logic             shift_en;
    logic             shift_msb;

    assign last_bit = (state == ST_SHIFT) && (bit_cnt == LAST_CNT);
    assign load_en  = hold_full && ((state == ST_IDLE) || last_bit);
    assign shift_en = (state == ST_SHIFT) && !last_bit;
    assign p_ready  = !hold_full;

    // Accept only fills an empty buffer and load only drains a full one, so they never collide.
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            hold_word <= '0;
            hold_full <= 1'b0;
        end else begin
            if (p_valid && !hold_full) begin
                hold_word <= p_i;
                hold_full <= 1'b1;
            end
            if (load_en) begin
                state     <= ST_SHIFT;
                bit_cnt   <= '0;
                hold_full <= 1'b0;
            end else if (last_bit) begin
                state   <= ST_IDLE;
                bit_cnt <= '0;
            end else if (state == ST_SHIFT) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    piso_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk_fast (clk_fast),
        .rst_n    (rst_n),
        .load     (load_en),
        .shift    (shift_en),
        .d        (hold_word),
        .msb      (shift_msb)
    );

`ifdef PISO_PARITY_EN
    logic parity_bit;

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            parity_bit <= 1'b0;
        end else if (load_en) begin
            parity_bit <= ^hold_word;
        end
    end

    assign serial_out = (state == ST_SHIFT) &&
                        ((bit_cnt == LAST_CNT) ? parity_bit : shift_msb);
`else
    assign serial_out = (state == ST_SHIFT) && shift_msb;
`endif

    assign s_valid = (state == ST_SHIFT);
    assign s_last  = last_bit;

endmodule

// File: tb/tb_parallel_to_serial.sv
// Directed bench for parallel_to_serial: framing, back-to-back streaming, backpressure, reset abort.
module tb_parallel_to_serial;

`ifdef PISO_PARITY_EN
    localparam int FLEN = 9;
    localparam bit PAR  = 1'b1;
`else
    localparam int FLEN = 8;
    localparam bit PAR  = 1'b0;
`endif

    logic       clk_fast = 1'b0;
    logic       rst_n    = 1'b0;
    logic [7:0] p_i      = '0;
    logic       p_valid  = 1'b0;
    logic       p_ready;
    logic       serial_out;
    logic       s_valid;
    logic       s_last;

    int checks   = 0;
    int failures = 0;

    parallel_to_serial #(
        .WIDTH (8)
    ) dut (
        .clk_fast   (clk_fast),
        .rst_n      (rst_n),
        .p_i        (p_i),
        .p_valid    (p_valid),
        .p_ready    (p_ready),
        .serial_out (serial_out),
        .s_valid    (s_valid),
        .s_last     (s_last)
    );

    always #5 clk_fast = ~clk_fast;

    // Serial monitor: newest bit lands in bit 0 of the capture registers.
    int          cyc = 0;
    int          cap_n = 0;
    logic [63:0] cap_bits = '0;
    logic [63:0] cap_last = '0;
    int          bit_cyc [0:511];

    always @(negedge clk_fast) begin
        cyc = cyc + 1;
        if (s_valid === 1'b1) begin
            cap_bits = {cap_bits[62:0], serial_out};
            cap_last = {cap_last[62:0], s_last};
            if (cap_n < 512) bit_cyc[cap_n] = cyc;
            cap_n = cap_n + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] frame(input logic [7:0] w, input logic par);
        if (PAR) return {23'd0, w, par};
        return {24'd0, w};
    endfunction

    // Offers w until accepted; while not ready, p_i carries junk that must be ignored.
    task automatic send(input logic [7:0] w);
        bit done = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk_fast);
            p_valid = 1'b1;
            if (p_ready) begin
                p_i = w;
                @(posedge clk_fast);
                #1;
                done = 1'b1;
            end else begin
                p_i = w ^ 8'h5A;
            end
        end
        p_valid = 1'b0;
        if (!done) check_val("send_timeout", 0, 1);
    endtask

    task automatic wait_bits(input int target, input string tag);
        int t = 0;
        while (cap_n < target && t < 200) begin
            @(negedge clk_fast);
            #1;
            t++;
        end
        if (cap_n < target) check_val(tag, 32'(cap_n), 32'(target));
    endtask

    task automatic single_word(input logic [7:0] w, input logic par, input string tag);
        logic [31:0] f;
        f = frame(w, par);
        send(w);
        check_val({tag, "_ready_low"}, 32'(p_ready), 0);
        @(negedge clk_fast);
        check_val({tag, "_latency"}, 32'(s_valid), 0);
        for (int i = 0; i < FLEN; i++) begin
            @(negedge clk_fast);
            check_val($sformatf("%s_valid%0d", tag, i), 32'(s_valid), 1);
            check_val($sformatf("%s_bit%0d", tag, i), 32'(serial_out), 32'(f[FLEN-1-i]));
            check_val($sformatf("%s_last%0d", tag, i), 32'(s_last), 32'(i == FLEN - 1));
        end
        @(negedge clk_fast);
        check_val({tag, "_idle_after"}, 32'(s_valid), 0);
        check_val({tag, "_ready_after"}, 32'(p_ready), 1);
    endtask

    initial begin
        int n0;
        logic [31:0] exp_bits;
        logic [31:0] exp_last;

        // Reset
        repeat (3) @(negedge clk_fast);
        check_val("rst_serial_out", 32'(serial_out), 0);
        check_val("rst_s_valid", 32'(s_valid), 0);
        check_val("rst_s_last", 32'(s_last), 0);
        check_val("rst_p_ready", 32'(p_ready), 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_fast);
        check_val("post_rst_s_valid", 32'(s_valid), 0);

        // Single words (0xB5 has odd ones count, 0x03 even)
        single_word(8'b1011_0101, 1'b1, "w_b5");
        single_word(8'h03, 1'b0, "w_03");

        // Back-to-back
        n0 = cap_n;
        send(8'hA5);
        send(8'h3C);
        check_val("b2b_ready_held", 32'(p_ready), 0);
        wait_bits(n0 + 2 * FLEN, "b2b_timeout");
        exp_bits = (frame(8'hA5, 1'b0) << FLEN) | frame(8'h3C, 1'b0);
        exp_last = (32'd1 << FLEN) | 32'd1;
        check_val("b2b_bits", cap_bits[31:0] & ((32'd1 << (2 * FLEN)) - 1), exp_bits);
        check_val("b2b_last", cap_last[31:0] & ((32'd1 << (2 * FLEN)) - 1), exp_last);
        check_val("b2b_contig", 32'(bit_cyc[n0 + 2 * FLEN - 1] - bit_cyc[n0]), 32'(2 * FLEN - 1));
        repeat (4) @(negedge clk_fast);
        check_val("b2b_count", 32'(cap_n - n0), 32'(2 * FLEN));

        // Backpressure, three words offered continuously
        n0 = cap_n;
        send(8'h01);
        send(8'h7E);
        send(8'hE0);
        wait_bits(n0 + 3 * FLEN, "bp_timeout");
        exp_bits = (frame(8'h01, 1'b1) << (2 * FLEN)) | (frame(8'h7E, 1'b0) << FLEN)
                   | frame(8'hE0, 1'b1);
        exp_last = (32'd1 << (2 * FLEN)) | (32'd1 << FLEN) | 32'd1;
        check_val("bp_bits", cap_bits[31:0] & ((32'd1 << (3 * FLEN)) - 1), exp_bits);
        check_val("bp_last", cap_last[31:0] & ((32'd1 << (3 * FLEN)) - 1), exp_last);
        check_val("bp_contig", 32'(bit_cyc[n0 + 3 * FLEN - 1] - bit_cyc[n0]), 32'(3 * FLEN - 1));
        repeat (6) @(negedge clk_fast);
        check_val("bp_count", 32'(cap_n - n0), 32'(3 * FLEN));
        check_val("bp_idle", 32'(s_valid), 0);

        // Reset mid-frame with a word held
        n0 = cap_n;
        send(8'hFF);
        send(8'h0F);
        wait_bits(n0 + 3, "midrst_timeout");
        check_val("midrst_bits", 32'(cap_bits[2:0]), 32'h7);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst_serial_out", 32'(serial_out), 0);
        check_val("midrst_s_valid", 32'(s_valid), 0);
        check_val("midrst_s_last", 32'(s_last), 0);
        check_val("midrst_p_ready", 32'(p_ready), 1);
        repeat (2) @(negedge clk_fast);
        rst_n = 1'b1;
        n0 = cap_n;
        repeat (2 * FLEN + 4) @(negedge clk_fast);
        #1;
        check_val("midrst_no_bits", 32'(cap_n - n0), 0);
        check_val("midrst_ready_after", 32'(p_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
